clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
// - Bank of NUM_CH independent programmable clock dividers on one fast clock.
// - Each channel gives a 1-cycle tick (clock enable) and a 50%-duty square wave.
// - Divisors are runtime-writable and take effect glitch-free at the channel's next wrap.
// - sync_i restarts all channels phase-aligned; feeds display refresh, 1 Hz and 5 Hz logic.
// PARAMETERS
// - NUM_CH    3          number of divider channels (>=1)
// - CNT_W     27         counter/divisor width; max divisor 2^CNT_W-1
// - INIT_DIV  100000000  reset divisor for every channel; 0 treated as 1
// - CH_W      2          wr_ch_i width; must be >= clog2(NUM_CH), min 1
// PORTS
// - clk_i     in   1       system clock, all logic on rising edge
// - rst       in   1       synchronous reset, active-high
// - en_i      in   NUM_CH  per-channel count enable
// - sync_i    in   1       restart all channels, phase-aligned
// - wr_en_i   in   1       divisor write strobe
// - wr_ch_i   in   CH_W    channel index for write
// - wr_div_i  in   CNT_W   new divisor N (tick period N cycles)
// - tick_o    out  NUM_CH  registered 1-cycle pulse per period
// - clk_o     out  NUM_CH  registered square wave, period 2N cycles
// BEHAVIOUR
// - Per channel: cnt[CNT_W], act_div (in use), pend_div (shadow), tick, sq.
// - Effective divisor E = max(act_div,1). Divisor 0 behaves as 1.
// - Reset: cnt=0, tick_o=0, clk_o=0, act_div=pend_div=INIT_DIV. Reset wins over all.
// - Priority per edge: rst > sync_i > en_i/counting. Writes apply in all non-reset cycles.
// - Write: wr_en_i && wr_ch_i<NUM_CH -> pend_div[wr_ch_i]<=wr_div_i. wr_ch_i>=NUM_CH ignored.
// - Count (en_i[c]=1, no sync): cnt!=E-1 -> cnt+1, tick<=0.
//   cnt==E-1 (wrap) -> cnt<=0, tick<=1, sq<=~sq, act_div<=pend_div.
// - Write coinciding with wrap on same channel: act_div loads wr_div_i (bypass).
// - Latency: from cnt=0 with en held, tick_o high in cycles N, 2N, 3N... (edge count).
// - E=1: tick_o stays high every cycle while enabled; clk_o toggles every cycle.
// - en_i[c]=0: cnt, sq and act_div hold; tick_o[c]<=0. Resume continues from held cnt.
// - sync_i: all cnt<=0, tick<=0, sq<=0, act_div<=pend_div (or write-bypass value).
// - sync_i ignores en_i. First ticks after sync: N cycles later on enabled channels.
// - Divisor shrink below current cnt cannot occur: act_div changes only at wrap/sync.
// - Channels fully independent; no cross-channel interaction except sync_i and wr bus.
// - Outputs driven from flops only; no combinational path from inputs to outputs.
// - cnt arithmetic modulo 2^CNT_W; unused upper cnt bits stay 0 by construction.
// TESTING
// - NUM_CH=3, INIT_DIV=4, en=3'b111 after rst: tick_o all high at cycles 4,8,12; clk_o period 8.
// - ch1 at cnt=1, write div=2: ch1 ticks at 4 (old), then 6,8,10; ch0/ch2 unchanged.
// - Write 0 then 1 to ch2: after next wrap tick_o[2] stays 1, clk_o[2] toggles each cycle.
// - Write ch0 div=6 on its wrap cycle: next ch0 tick exactly 6 cycles later (bypass).
// - ch0 en low 3 cycles at cnt=2: no tick, cnt holds 2; on resume tick after 2 cycles.
// - sync_i mid-count, divs 4/5/7: clk_o=0, ticks at 4/5/7 after sync; wr_ch_i=3 ignored.
// - rst mid-count with pending write: outputs 0, divisors back to INIT_DIV, write discarded.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank
// Bank of NUM_CH independent programmable clock dividers running on one fast
// clock. Each channel produces a one-cycle tick (usable as a clock enable) and
// a 50%-duty square wave. Divisors are written into a shadow register and only
// take effect when the channel wraps or on a sync, so output periods never
// glitch. sync_i restarts every channel phase-aligned.
//
// Ports
//   clk_i     in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active-high
//   en_i      in   NUM_CH  per-channel count enable
//   sync_i    in   1       restart all channels phase-aligned
//   wr_en_i   in   1       divisor write strobe
//   wr_ch_i   in   CH_W    channel index for the write
//   wr_div_i  in   CNT_W   new divisor N (tick period N cycles, 0 acts as 1)
//   tick_o    out  NUM_CH  registered one-cycle pulse per period
//   clk_o     out  NUM_CH  registered square wave, period 2N cycles

module clk_div_bank #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 27,
  parameter int INIT_DIV = 100000000,
  parameter int CH_W     = 2
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(INIT_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    logic             tick_q;
    logic             sq_q;

    logic             wr_hit;
    logic [CNT_W-1:0] eff_div;
    logic             wrap;
    logic [CNT_W-1:0] next_div;

    // Indices at or above NUM_CH never match any channel, so they are ignored.
    assign wr_hit   = wr_en_i && (32'(wr_ch_i) == c);
    // A divisor of 0 is treated as 1 so the channel never stalls.
    assign eff_div  = (act_div == '0) ? ONE : act_div;
    assign wrap     = (cnt == eff_div - ONE);
    // A write landing on the same edge as a wrap/sync is used immediately.
    assign next_div = wr_hit ? wr_div_i : pend_div;

    always_ff @(posedge clk_i) begin
      if (rst) begin
        cnt      <= '0;
        act_div  <= RESET_DIV;
        pend_div <= RESET_DIV;
        tick_q   <= 1'b0;
        sq_q     <= 1'b0;
      end else begin
        if (wr_hit) begin
          pend_div <= wr_div_i;
        end
        if (sync_i) begin
          cnt     <= '0;
          tick_q  <= 1'b0;
          sq_q    <= 1'b0;
          act_div <= next_div;
        end else if (en_i[c]) begin
          if (wrap) begin
            cnt     <= '0;
            tick_q  <= 1'b1;
            sq_q    <= ~sq_q;
            act_div <= next_div;
          end else begin
            cnt    <= cnt + ONE;
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign tick_o[c] = tick_q;
    assign clk_o[c]  = sq_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
// Directed test of clk_div_bank with NUM_CH=3, INIT_DIV=4. Each scenario
// starts from reset; edge numbers in the expectations count rising edges
// after reset release with all channels enabled.

module tb_clk_div_bank;

  logic        clk_i;
  logic        rst;
  logic [2:0]  en_i;
  logic        sync_i;
  logic        wr_en_i;
  logic [1:0]  wr_ch_i;
  logic [26:0] wr_div_i;
  logic [2:0]  tick_o;
  logic [2:0]  clk_o;

  int num_checks = 0;
  int num_fails  = 0;

  clk_div_bank #(
    .NUM_CH   (3),
    .CNT_W    (27),
    .INIT_DIV (4),
    .CH_W     (2)
  ) dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .en_i     (en_i),
    .sync_i   (sync_i),
    .wr_en_i  (wr_en_i),
    .wr_ch_i  (wr_ch_i),
    .wr_div_i (wr_div_i),
    .tick_o   (tick_o),
    .clk_o    (clk_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive a divisor write for exactly one edge.
  task automatic applyStimulus(input logic [1:0] ch, input logic [26:0] div);
    wr_en_i  = 1'b1;
    wr_ch_i  = ch;
    wr_div_i = div;
    step(1);
    wr_en_i  = 1'b0;
  endtask

  // Hold reset for two edges, then release with the given enables.
  task automatic doReset(input logic [2:0] en);
    rst     = 1'b1;
    en_i    = 3'b000;
    sync_i  = 1'b0;
    wr_en_i = 1'b0;
    step(2);
    rst  = 1'b0;
    en_i = en;
  endtask

  initial begin
    rst      = 1'b1;
    en_i     = 3'b000;
    sync_i   = 1'b0;
    wr_en_i  = 1'b0;
    wr_ch_i  = 2'd0;
    wr_div_i = '0;

    // Scenario 1: reset state and plain divide-by-4.
    $display("[TB] scenario 1: reset and divide by 4");
    doReset(3'b111);
    checkOutput("reset tick", 32'(tick_o), 32'h0);
    checkOutput("reset clk", 32'(clk_o), 32'h0);
    step(3);
    checkOutput("s1 e3 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s1 e4 tick", 32'(tick_o), 32'h7);
    checkOutput("s1 e4 clk", 32'(clk_o), 32'h7);
    step(1);
    checkOutput("s1 e5 tick", 32'(tick_o), 32'h0);
    checkOutput("s1 e5 clk", 32'(clk_o), 32'h7);
    step(3);
    checkOutput("s1 e8 tick", 32'(tick_o), 32'h7);
    checkOutput("s1 e8 clk", 32'(clk_o), 32'h0);
    step(4);
    checkOutput("s1 e12 tick", 32'(tick_o), 32'h7);
    checkOutput("s1 e12 clk", 32'(clk_o), 32'h7);

    // Scenario 2: ch1 rewritten to 2 mid-period, old period finishes first.
    $display("[TB] scenario 2: shadowed divisor write");
    doReset(3'b111);
    step(1);
    applyStimulus(2'd1, 27'd2);
    step(2);
    checkOutput("s2 e4 tick", 32'(tick_o), 32'h7);
    step(2);
    checkOutput("s2 e6 tick", 32'(tick_o), 32'h2);
    checkOutput("s2 e6 clk", 32'(clk_o), 32'h5);
    step(1);
    checkOutput("s2 e7 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s2 e8 tick", 32'(tick_o), 32'h7);
    step(2);
    checkOutput("s2 e10 tick", 32'(tick_o), 32'h2);
    checkOutput("s2 e10 clk", 32'(clk_o), 32'h0);

    // Scenario 3: divisor 0 and 1 both give a tick every cycle.
    $display("[TB] scenario 3: divisor 0 and 1");
    doReset(3'b111);
    applyStimulus(2'd2, 27'd0);
    applyStimulus(2'd2, 27'd1);
    step(2);
    checkOutput("s3 e4 tick", 32'(tick_o), 32'h7);
    checkOutput("s3 e4 clk", 32'(clk_o), 32'h7);
    applyStimulus(2'd0, 27'd0);
    checkOutput("s3 e5 tick", 32'(tick_o), 32'h4);
    checkOutput("s3 e5 clk", 32'(clk_o), 32'h3);
    step(1);
    checkOutput("s3 e6 tick", 32'(tick_o), 32'h4);
    checkOutput("s3 e6 clk", 32'(clk_o), 32'h7);
    step(1);
    checkOutput("s3 e7 clk", 32'(clk_o), 32'h3);
    step(1);
    checkOutput("s3 e8 tick", 32'(tick_o), 32'h7);
    checkOutput("s3 e8 clk", 32'(clk_o), 32'h4);
    step(1);
    checkOutput("s3 e9 tick", 32'(tick_o), 32'h5);
    checkOutput("s3 e9 clk", 32'(clk_o), 32'h1);

    // Scenario 4: write on the wrap edge is used immediately.
    $display("[TB] scenario 4: write bypass on wrap");
    doReset(3'b111);
    step(3);
    applyStimulus(2'd0, 27'd6);
    checkOutput("s4 e4 tick", 32'(tick_o), 32'h7);
    step(4);
    checkOutput("s4 e8 tick", 32'(tick_o), 32'h6);
    step(2);
    checkOutput("s4 e10 tick", 32'(tick_o), 32'h1);
    checkOutput("s4 e10 clk", 32'(clk_o), 32'h0);

    // Scenario 5: ch0 paused for 3 cycles at cnt=2.
    $display("[TB] scenario 5: enable hold");
    doReset(3'b111);
    step(2);
    en_i = 3'b110;
    step(2);
    checkOutput("s5 e4 tick", 32'(tick_o), 32'h6);
    step(1);
    checkOutput("s5 e5 tick", 32'(tick_o), 32'h0);
    en_i = 3'b111;
    step(1);
    checkOutput("s5 e6 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s5 e7 tick", 32'(tick_o), 32'h1);
    checkOutput("s5 e7 clk", 32'(clk_o), 32'h7);

    // Scenario 6: sync restart with divisors 4/5/7; write to index 3 ignored.
    $display("[TB] scenario 6: sync restart");
    doReset(3'b111);
    applyStimulus(2'd1, 27'd5);
    applyStimulus(2'd2, 27'd7);
    applyStimulus(2'd3, 27'd2);
    step(1);
    checkOutput("s6 e4 tick", 32'(tick_o), 32'h7);
    step(2);
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    checkOutput("s6 sync tick", 32'(tick_o), 32'h0);
    checkOutput("s6 sync clk", 32'(clk_o), 32'h0);
    step(3);
    checkOutput("s6 +3 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s6 +4 tick", 32'(tick_o), 32'h1);
    step(1);
    checkOutput("s6 +5 tick", 32'(tick_o), 32'h2);
    step(1);
    checkOutput("s6 +6 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s6 +7 tick", 32'(tick_o), 32'h4);
    checkOutput("s6 +7 clk", 32'(clk_o), 32'h7);

    // Scenario 7: reset mid-count discards a pending write.
    $display("[TB] scenario 7: reset with pending write");
    doReset(3'b111);
    step(5);
    checkOutput("s7 e5 clk", 32'(clk_o), 32'h7);
    applyStimulus(2'd1, 27'd3);
    rst = 1'b1;
    step(1);
    checkOutput("s7 rst tick", 32'(tick_o), 32'h0);
    checkOutput("s7 rst clk", 32'(clk_o), 32'h0);
    rst = 1'b0;
    step(3);
    checkOutput("s7 r3 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s7 r4 tick", 32'(tick_o), 32'h7);
    step(3);
    checkOutput("s7 r7 tick", 32'(tick_o), 32'h0);
    step(1);
    checkOutput("s7 r8 tick", 32'(tick_o), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
